serial_sub16: RTL
=================

# serial_sub16

Bit-serial 16-bit subtractor computing `a - b - b_in`, one bit per clock, LSB first, through a single full-adder cell and a registered carry. It is the area-minimal inverse-operation companion to the 16-bit ripple-carry adder datapath. It also serves as the subtract stage for multi-cycle arithmetic units that can tolerate a 16-cycle latency. A start/busy/done handshake frames each operation, and the results register holds the last result until the next completion.

## Interface
- `WIDTH`, 16: operand width; the cycle counter is sized `$clog2(WIDTH)+1`.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request; sampled only when `busy`=0.
- `a`  input  WIDTH  minuend; latched on an accepted start.
- `b`  input  WIDTH  subtrahend; latched on an accepted start.
- `b_in`  input  1  borrow-in; latched on an accepted start.
- `busy`  output  1  operation in progress.
- `done`  output  1  one-cycle pulse; results valid from this cycle onward.
- `diff`  output  WIDTH  `(a - b - b_in) mod 2^WIDTH`.
- `b_out`  output  1  unsigned borrow: 1 iff `a < b + b_in`.
- `ovf`  output  1  signed overflow: `(a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB])`.
- `zero`  output  1  `diff == 0`.
- Clock and reset: one clock; reset is synchronous and active-high.

## Operation
- FSM states:
  - IDLE: `busy`=0, `done`=0.
  - RUN: `busy`=1.
  - DONE: `busy`=0, `done`=1.
- Transitions:
  - IDLE→RUN when `start`=1.
  - RUN→DONE after WIDTH bit steps.
  - DONE→RUN when `start`=1, otherwise DONE→IDLE.
- Accepted start (IDLE or DONE with `start`=1):
  - Load shift register A←`a` and B←`~b`.
  - Load carry flop c←`~b_in`.
  - Clear the bit counter and the partial-result shift register.
  - Latch `a[MSB]` and `b[MSB]` for the `ovf` computation.
- Each RUN cycle:
  - Full adder computes `s = A[0] ^ B[0] ^ c` and `co = maj(A[0], B[0], c)`.
  - `s` shifts into the partial-result MSB; A and B shift right; c←`co`; counter increments.
- Final RUN cycle (counter = WIDTH-1), at the same edge:
  - Copy the complete partial result into `diff`.
  - Set `b_out`←`~co`.
  - Compute `zero` and `ovf` from the completed value.
  - Enter DONE.
- `diff`, `b_out`, `ovf`, and `zero` change only at a completion edge or at reset. They hold otherwise, including through IDLE and subsequent RUN cycles.
- `start` while `busy`=1 is ignored; operands are not re-latched.
- `a`, `b`, and `b_in` may change freely after the accepting edge without affecting the operation in flight.

## Timing
- Reset values: state=IDLE; `busy`=0, `done`=0, `diff`=0, `b_out`=0, `ovf`=0, `zero`=0. Internal registers are cleared.
- With `start` high in cycle 0 (IDLE):
  - `busy`=1 in cycles 1..WIDTH.
  - `done`=1 in cycle WIDTH+1 (cycle 17 for the default).
  - New results are visible in that same cycle 17.
- Throughput:
  - Back-to-back: `start` high during the DONE cycle is accepted, so `busy` rises the next cycle. Period is WIDTH+1 cycles.
  - From IDLE, the next start is accepted any later cycle.
- `done` is high for exactly one cycle per accepted start. `done` and `busy` are never high together.
- `rst` in any state, including mid-RUN, returns to the reset values at that edge:
  - The aborted operation produces no `done`.
  - `start` in the reset cycle is ignored.
- Carry chain polarity: subtraction is `a + ~b + ~b_in`, and borrow-out is the inverted final carry.

## Test plan
- Reset, then `a`=0x1234, `b`=0x0234, `b_in`=0 → `done` in cycle 17; `diff`=0x1000, `b_out`=0, `ovf`=0, `zero`=0.
- `a`=0x0000, `b`=0x0001, `b_in`=0 → `diff`=0xFFFF, `b_out`=1, `ovf`=0. Then `a`=0x8000, `b`=0x0001 → `diff`=0x7FFF, `b_out`=0, `ovf`=1.
- `a`=0x5A5A, `b`=0x5A5A, `b_in`=0 → `diff`=0x0000, `zero`=1, `b_out`=0. Then the same operands with `b_in`=1 → `diff`=0xFFFF, `b_out`=1, `zero`=0.
- `start` with `a`=0x0010, `b`=0x0001; re-pulse `start` with `a`=0xFFFF in cycle 5 → pulse ignored; `diff`=0x000F in cycle 17 and exactly one `done`.
- `start` held high continuously with `a`=0x0003, `b`=0x0001 → `done` in cycles 17, 34, 51; `busy` low only in the `done` cycles; `diff`=0x0002 each time.
- Complete an operation giving `diff`=0x1000, start another, assert `rst` in cycle 8 → no `done`; all outputs 0 on the next cycle; a later `start` completes normally.
- Random regression: 10k random `a`/`b`/`b_in` triples checked against a reference model of `a - b - b_in` and all four flags.

Source files
------------

// File: rtl/serial_sub16.sv
// Bit-serial subtractor: a - b - b_in evaluated LSB first through one full-adder
// cell as a + ~b + ~b_in, with a start/busy/done handshake and held results.
module serial_sub16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             b_out_q, b_out_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] part_next;

  // Single full-adder cell on the LSBs of the shifting operands.
  always_comb begin
    fa_s      = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
    fa_co     = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);
    part_next = {fa_s, part_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    part_d  = part_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    diff_d  = diff_q;
    b_out_d = b_out_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_sh_d  = a;
          b_sh_d  = ~b;
          c_d     = ~b_in;
          cnt_d   = '0;
          part_d  = '0;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        part_d = part_next;
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        c_d    = fa_co;
        cnt_d  = cnt_q + CW'(1);
        // Results are published from the bit being shifted in on this edge,
        // so done and the new values appear in the same cycle.
        if (cnt_q == LAST) begin
          state_d = DONE;
          diff_d  = part_next;
          b_out_d = ~fa_co;
          zero_d  = (part_next == '0);
          ovf_d   = (a_msb_q != b_msb_q) && (part_next[WIDTH-1] != a_msb_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      part_q  <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      diff_q  <= '0;
      b_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      part_q  <= part_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      diff_q  <= diff_d;
      b_out_q <= b_out_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    busy  = (state_q == RUN);
    done  = (state_q == DONE);
    diff  = diff_q;
    b_out = b_out_q;
    ovf   = ovf_q;
    zero  = zero_q;
  end

endmodule
